// File: rtl/adc_drp_pkg.sv
// Shared definitions for the ADC DRP responder.
//   - DRP register addresses of the emulated XADC map
//   - channel number reported on channel_out
//   - conversion state encoding
package adc_drp_pkg;

    localparam logic [6:0] ADDR_VAUX0  = 7'h10;
    localparam logic [6:0] ADDR_MAX    = 7'h30;
    localparam logic [6:0] ADDR_MIN    = 7'h31;
    localparam logic [6:0] ADDR_CFG    = 7'h40;
    localparam logic [6:0] ADDR_LOWTH  = 7'h50;
    localparam logic [6:0] ADDR_HIGHTH = 7'h51;

    localparam logic [4:0] CHANNEL_VAUX0 = 5'h10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

endpackage

// File: rtl/drp_slave_port.sv
// DRP slave handshake: accepts one request at a time, returns drdy_out exactly
// DRP_LATENCY clocks after acceptance, and flags requests that collide with a
// pending one.
//   clk, reset_in        clock, async active-high reset
//   den_in/dwe_in        request strobe and write qualifier
//   daddr_in/di_in       request address and write data
//   err_clr              clears the sticky collision flag
//   rd_data              register read word for rd_addr, supplied by the owner of the map
//   rd_addr              address being read at acceptance
//   wr_en/wr_addr/wr_data  single-cycle write strobe at acceptance
//   do_out/drdy_out      DRP response
//   err_out              sticky collision flag
module drp_slave_port #(
    parameter int DRP_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    input  logic        err_clr,
    input  logic [15:0] rd_data,
    output logic [6:0]  rd_addr,
    output logic        wr_en,
    output logic [6:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        err_out
);

    localparam logic [3:0] LAT_LOAD = 4'(DRP_LATENCY - 1);

    logic        pending_q, pending_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] do_q, do_d;
    logic        drdy_q, drdy_d;
    logic        err_q, err_d;
    logic        accept;
    logic [15:0] rd_word;

    assign accept  = den_in & ~pending_q;
    assign rd_addr = daddr_in;
    assign wr_en   = accept & dwe_in;
    assign wr_addr = daddr_in;
    assign wr_data = di_in;
    // a write answers with zero data
    assign rd_word = dwe_in ? 16'h0000 : rd_data;

    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        do_d      = do_q;
        drdy_d    = 1'b0;
        err_d     = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end
        if (den_in && pending_q) begin
            err_d = 1'b1;
        end

        if (accept) begin
            if (LAT_LOAD == 4'd0) begin
                drdy_d = 1'b1;
                do_d   = rd_word;
            end else begin
                pending_d = 1'b1;
                cnt_d     = LAT_LOAD;
                hold_d    = rd_word;
            end
        end else if (pending_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                pending_d = 1'b0;
                drdy_d    = 1'b1;
                do_d      = hold_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            pending_q <= 1'b0;
            cnt_q     <= 4'd0;
            hold_q    <= 16'h0000;
            do_q      <= 16'h0000;
            drdy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            do_q      <= do_d;
            drdy_q    <= drdy_d;
            err_q     <= err_d;
        end
    end

    assign do_out   = do_q;
    assign drdy_out = drdy_q;
    assign err_out  = err_q;

endmodule

// File: rtl/adc_drp_responder.sv
// XADC stand-in on the PSM path: turns a held 12-bit sample into periodic
// conversions and serves the DRP register map.
//   clk, reset_in          clock, async active-high reset
//   sample_in/sample_valid raw sample and its qualifier
//   den_in/dwe_in/daddr_in/di_in  DRP request
//   do_out/drdy_out        DRP response
//   channel_out            fixed vaux0 channel
//   eoc_out/eos_out        end-of-conversion pulse (single-channel sequence)
//   busy_out               conversion in progress
//   alarm_out              low-voltage alarm with hysteresis
//   err_out                sticky DRP collision flag
//
// state | meaning
// IDLE  | conversions disabled, waiting for 0x40[0]
// CONV  | counting CONV_CYCLES clocks, busy_out high
// DONE  | one cycle: publish result, pulse eoc_out, update max/min/alarm
module adc_drp_responder
    import adc_drp_pkg::*;
#(
    parameter int          CONV_CYCLES = 26,
    parameter int          DRP_LATENCY = 2,
    parameter logic [15:0] LOW_TH_RST  = 16'hE1A0,
    parameter logic [15:0] HIGH_TH_RST = 16'hE3C0
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic [11:0] sample_in,
    input  logic        sample_valid,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic [4:0]  channel_out,
    output logic        eoc_out,
    output logic        eos_out,
    output logic        busy_out,
    output logic        alarm_out,
    output logic        err_out
);

    localparam int          CW       = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CONV_CYCLES - 1);

    conv_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   held_q, held_d;
    logic [15:0]   vaux_q, vaux_d;
    logic [15:0]   max_q, max_d;
    logic [15:0]   min_q, min_d;
    logic          cfg_en_q, cfg_en_d;
    logic [15:0]   low_q, low_d;
    logic [15:0]   high_q, high_d;
    logic          alarm_q, alarm_d;

    logic [15:0]   conv_val;
    logic [6:0]    rd_addr;
    logic [15:0]   rd_data;
    logic          wr_en;
    logic [6:0]    wr_addr;
    logic [15:0]   wr_data;
    logic          err_clr;

    assign conv_val = {held_q, 4'h0};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        held_d   = held_q;
        vaux_d   = vaux_q;
        max_d    = max_q;
        min_d    = min_q;
        cfg_en_d = cfg_en_q;
        low_d    = low_q;
        high_d   = high_q;
        alarm_d  = alarm_q;

        if (sample_valid) begin
            held_d = sample_in;
        end

        case (state_q)
            IDLE: begin
                if (cfg_en_q) begin
                    state_d = CONV;
                    cnt_d   = CNT_LOAD;
                end
            end
            CONV: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                vaux_d = conv_val;
                if (conv_val > max_q) max_d = conv_val;
                if (conv_val < min_q) min_d = conv_val;
                // between the thresholds the alarm keeps its previous value
                if (held_q < low_q[15:4]) begin
                    alarm_d = 1'b1;
                end else if (held_q > high_q[15:4]) begin
                    alarm_d = 1'b0;
                end
                if (cfg_en_q) begin
                    state_d = CONV;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            case (wr_addr)
                ADDR_CFG:    cfg_en_d = wr_data[0];
                ADDR_LOWTH:  low_d    = wr_data;
                ADDR_HIGHTH: high_d   = wr_data;
                default: ;
            endcase
        end
    end

    // Result registers are read through their next value so a read landing in
    // DONE sees the conversion being published (write-first).
    always_comb begin
        rd_data = 16'h0000;
        case (rd_addr)
            ADDR_VAUX0:  rd_data = vaux_d;
            ADDR_MAX:    rd_data = max_d;
            ADDR_MIN:    rd_data = min_d;
            ADDR_CFG:    rd_data = {15'h0000, cfg_en_q};
            ADDR_LOWTH:  rd_data = low_q;
            ADDR_HIGHTH: rd_data = high_q;
            default:     rd_data = 16'h0000;
        endcase
    end

    assign err_clr = wr_en && (wr_addr == ADDR_CFG) && wr_data[15];

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            held_q   <= 12'h000;
            vaux_q   <= 16'h0000;
            max_q    <= 16'h0000;
            min_q    <= 16'hFFFF;
            cfg_en_q <= 1'b1;
            low_q    <= LOW_TH_RST;
            high_q   <= HIGH_TH_RST;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            held_q   <= held_d;
            vaux_q   <= vaux_d;
            max_q    <= max_d;
            min_q    <= min_d;
            cfg_en_q <= cfg_en_d;
            low_q    <= low_d;
            high_q   <= high_d;
            alarm_q  <= alarm_d;
        end
    end

    drp_slave_port #(
        .DRP_LATENCY (DRP_LATENCY)
    ) u_drp (
        .clk      (clk),
        .reset_in (reset_in),
        .den_in   (den_in),
        .dwe_in   (dwe_in),
        .daddr_in (daddr_in),
        .di_in    (di_in),
        .err_clr  (err_clr),
        .rd_data  (rd_data),
        .rd_addr  (rd_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .do_out   (do_out),
        .drdy_out (drdy_out),
        .err_out  (err_out)
    );

    assign channel_out = CHANNEL_VAUX0;
    assign busy_out    = (state_q == CONV);
    assign eoc_out     = (state_q == DONE);
    assign eos_out     = eoc_out;
    assign alarm_out   = alarm_q;

endmodule

// File: doc/adc_drp_responder.md
Name: adc_drp_responder

Overview:
- Synthesizable DRP responder that stands in for the XADC wizard instance on the PSM path, in both simulation and ADC-less builds.
- Converts an externally supplied 12-bit sample stream into periodic conversions, using the same fields as the PSM consumer: eoc_out pulse, channel_out, busy_out, and the DRP read-back of address 0x10.
- The existing PSM controller drives den from eoc_out and reads address 0x10; this block is the other end of that DRP transaction.

Parameters:
- CONV_CYCLES, 26, clocks per conversion (busy_out high for the whole period); minimum 4.
- DRP_LATENCY, 2, clocks from accepted den to the drdy_out pulse; legal range 1..15.
- LOW_TH_RST, 16'hE1A0, reset value of the low threshold register (0x50).
- HIGH_TH_RST, 16'hE3C0, reset value of the high threshold register (0x51).

Ports:
- clk  in  1  system clock
- reset_in  in  1  asynchronous, active-high reset
- sample_in  in  12  raw sample presented by the testbench or sensor model
- sample_valid  in  1  qualifies sample_in; the held sample updates only when this is high
- den_in  in  1  DRP enable, single-cycle request
- dwe_in  in  1  DRP write enable, qualified by den_in
- daddr_in  in  7  DRP address
- di_in  in  16  DRP write data
- do_out  out  16  DRP read data
- drdy_out  out  1  DRP ready pulse
- channel_out  out  5  constant 5'h10 (vaux0)
- eoc_out  out  1  end-of-conversion pulse
- eos_out  out  1  equal to eoc_out (single-channel sequence)
- busy_out  out  1  conversion in progress
- alarm_out  out  1  low-voltage alarm with hysteresis
- err_out  out  1  sticky flag: den_in arrived while a transaction was pending

Behaviour:
- Reset (asynchronous, active-high), all outputs and registers:
  - do_out = 0, drdy_out = 0, eoc_out = 0, eos_out = 0, busy_out = 0, alarm_out = 0, err_out = 0.
  - Held sample = 0; reg 0x10 = 0; 0x30 (max) = 16'h0000; 0x31 (min) = 16'hFFFF.
  - 0x40 = 16'h0001 (bit0 = conversion enable).
  - 0x50 = LOW_TH_RST, 0x51 = HIGH_TH_RST.
- Sample capture: on each clock where sample_valid = 1, register sample_in into the held sample.
- Conversion FSM, states IDLE → CONV → DONE → CONV ...:
  - IDLE: enter CONV on the cycle after 0x40[0] = 1.
  - CONV: busy_out = 1 while counting CONV_CYCLES−1 down to 0. The terminal count moves to DONE.
  - DONE (1 cycle):
    - reg 0x10 ← {held sample, 4'b0}; update 0x30 and 0x31 with unsigned compare.
    - eoc_out = eos_out = 1 and busy_out = 0 in this cycle.
    - Return to CONV if 0x40[0] = 1, otherwise to IDLE.
  - Clearing 0x40[0] during CONV lets the current conversion finish.
- Alarm, evaluated in DONE on the new 0x10[15:4]:
  - less than 0x50[15:4] → alarm_out = 1;
  - greater than 0x51[15:4] → alarm_out = 0;
  - otherwise hold the current value.
- DRP handshake:
  - den_in is accepted when no transaction is pending. Address, dwe and di are latched.
  - drdy_out pulses exactly DRP_LATENCY cycles after acceptance, for one cycle. do_out is valid in that cycle and holds until the next drdy.
  - den_in while pending: ignored and err_out set. err_out is cleared only by reset or by a write to 0x40 with bit15 = 1.
- Read data: register contents sampled at acceptance. Unmapped addresses return 16'h0000.
- Read/write collision: a read of 0x10 accepted in the same cycle as DONE returns the new value (write-first).
- Writes:
  - Only 0x40, 0x50 and 0x51 are writable; 0x40 stores bit0 only.
  - Writes to any other address are dropped, but drdy_out still pulses; do_out on a write = 16'h0000.
  - Writes take effect at acceptance.
- Back-to-back den_in: legal only when spaced by at least DRP_LATENCY+1 cycles.
- eoc_out feeding den_in directly (PSM usage) must always complete, because CONV_CYCLES > DRP_LATENCY.

Decomposition:
- Package adc_drp_pkg:
  - address constants ADDR_VAUX0 = 7'h10, ADDR_MAX = 7'h30, ADDR_MIN = 7'h31, ADDR_CFG = 7'h40, ADDR_LOWTH = 7'h50, ADDR_HIGHTH = 7'h51;
  - CHANNEL_VAUX0 = 5'h10;
  - conversion state enum (IDLE, CONV, DONE).
- Sub-module drp_slave_port: accept/latency/drdy/err logic. It emits a write strobe and a read index, and takes read data back from the top, which keeps the register map in adc_drp_responder.

Test Plan:
- Reset release, sample_in = 12'hE00 valid → first eoc_out exactly CONV_CYCLES+1 clocks later; read 0x10 → drdy after 2 clocks with do_out = 16'hE000; alarm_out = 1; err_out = 0.
- Drive eoc_out → den_in with daddr 0x10, then step sample to 12'hE50 → next read gives 16'hE500 and alarm_out = 0; step to 12'hE2B → alarm_out stays 0 (hysteresis band).
- Write 0x50 = 16'hF000, then sample 12'hE50 → alarm_out = 1 at the next DONE; write to 0x10 is dropped (drdy still pulses, read-back unchanged).
- Second den_in one cycle after the first → single drdy, first request's data, err_out = 1; write 0x40 = 16'h8001 → err_out = 0, conversions continue.
- Samples 12'h100, 12'hF00, 12'h800 → 0x30 = 16'hF000, 0x31 = 16'h1000; read of unmapped 0x7F → 16'h0000.
- Assert reset_in mid-CONV with a pending read → busy_out, drdy_out, alarm_out drop immediately (async); no drdy after release; 0x50 back to 16'hE1A0.
